// File: rtl/exe_muldiv.sv
`timescale 1ns/1ps
// exe_muldiv -- iterative RV32M multiply/divide unit for the EXE stage.
//
// Takes operands straight from the ID/EXE register outputs. Raises a stall
// while an M-extension op is running. Delivers the 32-bit result on a
// one-cycle done pulse. Non-M instructions are ignored and never stalled.
//
// Multiplies use 32 shift-add steps on operand magnitudes.
// Divides use 32 restoring steps on operand magnitudes.
// Divide-by-zero and signed overflow are resolved without iterating.
//
// Optional build macro:
//   MULDIV_FAST_MUL_EN - all multiplies finish in one cycle through a
//                        combinational 33x33 signed multiply. Divides are
//                        unaffected.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   exe_valid, exe_rtype  EXE holds a real OP (R-type) instruction
//   exe_funct7/funct3     7'b0000001 selects M; funct3 selects the M op
//   exe_rs1_data/rs2_data forwarded source operands
//   exe_flush             abort any in-flight op, no done pulse
//   muldiv_stall          hold PC, IF/ID, ID/EXE; bubble into EXE/MEM
//   muldiv_busy           iterating (MUL or DIV state)
//   muldiv_done           one-cycle pulse, muldiv_result valid
//   muldiv_result         registered result, held until the next completion
module exe_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exe_valid,
    input  logic        exe_rtype,
    input  logic [6:0]  exe_funct7,
    input  logic [2:0]  exe_funct3,
    input  logic [31:0] exe_rs1_data,
    input  logic [31:0] exe_rs2_data,
    input  logic        exe_flush,
    output logic        muldiv_stall,
    output logic        muldiv_busy,
    output logic        muldiv_done,
    output logic [31:0] muldiv_result
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state_reg;
    logic [2:0]  op_reg;
    logic        negate_reg;
    logic [4:0]  count_reg;
    logic [31:0] opa_reg;     // multiplicand, or divisor
    logic [63:0] acc_reg;     // mul: {product hi, multiplier/product lo}; div: {remainder, dividend/quotient}
    logic [31:0] result_reg;
    logic        done_reg;
    logic        busy_reg;

    // ---------------- start decode ----------------
    logic start;
    logic is_div;
    logic sgn1, sgn2;
    logic neg1, neg2;
    logic [31:0] mag1, mag2;
    logic neg_in;
    logic div_zero, div_ovf;
    logic [31:0] special_result;

    assign start  = exe_valid & exe_rtype & (exe_funct7 == 7'b0000001)
                  & (state_reg == S_IDLE) & ~exe_flush;
    assign is_div = exe_funct3[2];

    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
    assign sgn1 = (exe_funct3 == 3'b001) | (exe_funct3 == 3'b010)
                | (exe_funct3 == 3'b100) | (exe_funct3 == 3'b110);
    assign sgn2 = (exe_funct3 == 3'b001) | (exe_funct3 == 3'b100)
                | (exe_funct3 == 3'b110);

    assign neg1 = sgn1 & exe_rs1_data[31];
    assign neg2 = sgn2 & exe_rs2_data[31];
    assign mag1 = neg1 ? (32'd0 - exe_rs1_data) : exe_rs1_data;
    assign mag2 = neg2 ? (32'd0 - exe_rs2_data) : exe_rs2_data;

    // Remainder follows the dividend sign; products and quotients follow
    // the sign difference of the operands.
    assign neg_in = (exe_funct3 == 3'b110) ? neg1 : (neg1 ^ neg2);

    assign div_zero = (exe_rs2_data == 32'd0);
    assign div_ovf  = ((exe_funct3 == 3'b100) | (exe_funct3 == 3'b110))
                    & (exe_rs1_data == 32'h8000_0000)
                    & (exe_rs2_data == 32'hFFFF_FFFF);

    always_comb begin
        special_result = 32'd0;
        if (div_zero)
            special_result = exe_funct3[1] ? exe_rs1_data : 32'hFFFF_FFFF;
        else
            special_result = exe_funct3[1] ? 32'd0 : 32'h8000_0000;
    end

`ifdef MULDIV_FAST_MUL_EN
    // 33-bit operands carry the sign extension for the signed variants.
    logic signed [32:0] fast_a, fast_b;
    logic signed [63:0] fast_prod;
    logic [31:0]        fast_word;

    assign fast_a    = {neg1 ? 1'b1 : 1'b0, exe_rs1_data};
    assign fast_b    = {neg2 ? 1'b1 : 1'b0, exe_rs2_data};
    assign fast_prod = fast_a * fast_b;
    assign fast_word = (exe_funct3 == 3'b000) ? fast_prod[31:0] : fast_prod[63:32];
`endif

    // ---------------- iteration datapath ----------------
    // Shift-add: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] mul_signed;
    logic [31:0] mul_word;

    assign mul_sum    = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opa_reg} : 33'd0);
    assign mul_next   = {mul_sum, acc_reg[31:1]};
    assign mul_signed = negate_reg ? (64'd0 - mul_next) : mul_next;
    assign mul_word   = (op_reg == 3'b000) ? mul_signed[31:0] : mul_signed[63:32];

    // Restoring divide: bring the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. When it fits the
    // difference is below the divisor, so 32-bit wrap-around is exact.
    logic [32:0] div_shifted;
    logic        div_fits;
    logic [31:0] div_sub;
    logic [63:0] div_next;
    logic [31:0] div_sel;
    logic [31:0] div_word;

    assign div_shifted = acc_reg[63:31];
    assign div_fits    = (div_shifted >= {1'b0, opa_reg});
    assign div_sub     = acc_reg[62:31] - opa_reg;
    assign div_next    = div_fits ? {div_sub, acc_reg[30:0], 1'b1}
                                  : {acc_reg[62:0], 1'b0};
    assign div_sel     = op_reg[1] ? div_next[63:32] : div_next[31:0];
    assign div_word    = negate_reg ? (32'd0 - div_sel) : div_sel;

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            op_reg     <= 3'd0;
            negate_reg <= 1'b0;
            count_reg  <= 5'd0;
            opa_reg    <= 32'd0;
            acc_reg    <= 64'd0;
            result_reg <= 32'd0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else if (exe_flush) begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg     <= exe_funct3;
                        negate_reg <= neg_in;
                        count_reg  <= 5'd0;
                        if (!is_div) begin
`ifdef MULDIV_FAST_MUL_EN
                            result_reg <= fast_word;
                            state_reg  <= S_DONE;
                            done_reg   <= 1'b1;
`else
                            opa_reg   <= mag1;
                            acc_reg   <= {32'd0, mag2};
                            state_reg <= S_MUL;
                            busy_reg  <= 1'b1;
`endif
                        end else if (div_zero | div_ovf) begin
                            result_reg <= special_result;
                            state_reg  <= S_DONE;
                            done_reg   <= 1'b1;
                        end else begin
                            opa_reg   <= mag2;
                            acc_reg   <= {32'd0, mag1};
                            state_reg <= S_DIV;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_reg   <= mul_next;
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == 5'd31) begin
                        result_reg <= mul_word;
                        state_reg  <= S_DONE;
                        done_reg   <= 1'b1;
                        busy_reg   <= 1'b0;
                    end
                end
                S_DIV: begin
                    acc_reg   <= div_next;
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == 5'd31) begin
                        result_reg <= div_word;
                        state_reg  <= S_DONE;
                        done_reg   <= 1'b1;
                        busy_reg   <= 1'b0;
                    end
                end
                default: begin
                    // DONE: the finished instruction advances this cycle.
                    // It cannot retrigger because the state is not IDLE.
                    state_reg <= S_IDLE;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign muldiv_stall  = ~exe_flush & (start | (state_reg == S_MUL) | (state_reg == S_DIV));
    assign muldiv_busy   = busy_reg;
    assign muldiv_done   = done_reg;
    assign muldiv_result = result_reg;

endmodule

// File: tb/tb_exe_muldiv.sv
`timescale 1ns/1ps
// Self-checking bench for exe_muldiv: directed cases, randomized ops against
// an arithmetic reference model, flush, non-M passthrough and async reset.
module tb_exe_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exe_valid = 1'b0;
    logic        exe_rtype = 1'b0;
    logic [6:0]  exe_funct7 = 7'd0;
    logic [2:0]  exe_funct3 = 3'd0;
    logic [31:0] exe_rs1_data = 32'd0;
    logic [31:0] exe_rs2_data = 32'd0;
    logic        exe_flush = 1'b0;
    logic        muldiv_stall;
    logic        muldiv_busy;
    logic        muldiv_done;
    logic [31:0] muldiv_result;

    int total = 0;
    int bad = 0;
    logic [31:0] last_exp = 32'd0;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    exe_muldiv dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .exe_valid     (exe_valid),
        .exe_rtype     (exe_rtype),
        .exe_funct7    (exe_funct7),
        .exe_funct3    (exe_funct3),
        .exe_rs1_data  (exe_rs1_data),
        .exe_rs2_data  (exe_rs2_data),
        .exe_flush     (exe_flush),
        .muldiv_stall  (muldiv_stall),
        .muldiv_busy   (muldiv_busy),
        .muldiv_done   (muldiv_done),
        .muldiv_result (muldiv_result)
    );

    always #5 clk = ~clk;

    // Reference result from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycle (counted from start) at which done should pulse.
    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return FAST_MUL ? 1 : 33;
        if (b == 32'd0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int lat;
        int cyc;
        int stalls;
        bit seen;
        @(posedge clk); #1;
        exe_valid = 1'b1; exe_rtype = 1'b1; exe_funct7 = 7'b0000001;
        exe_funct3 = f; exe_rs1_data = a; exe_rs2_data = b; exe_flush = 1'b0;
        exp = ref_result(f, a, b);
        lat = ref_latency(f, a, b);
        cyc = 0; stalls = 0; seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            if (muldiv_stall) stalls++;
            if (muldiv_done) seen = 1'b1;
            else cyc++;
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        check("done_cycle", 64'(cyc), 64'(lat));
        check("stall_cycles", 64'(stalls), 64'(lat));
        check("result", {32'd0, muldiv_result}, {32'd0, exp});
        $display("op f3=%0d rs1=%h rs2=%h result=%h expected=%h done_cycle=%0d stalls=%0d",
                 f, a, b, muldiv_result, exp, cyc, stalls);
        last_exp = exp;
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        exe_valid = 1'b0; exe_flush = 1'b0;
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        bit          hit;

        // Reset state
        #3;
        check("reset_stall", {63'd0, muldiv_stall}, 64'd0);
        check("reset_busy", {63'd0, muldiv_busy}, 64'd0);
        check("reset_done", {63'd0, muldiv_done}, 64'd0);
        check("reset_result", {32'd0, muldiv_result}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op(3'd3, 32'h8000_0000, 32'h8000_0000);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd5, 32'd100, 32'd7);
        run_op(3'd7, 32'd100, 32'd7);
        run_op(3'd5, 32'd5, 32'd0);
        run_op(3'd6, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Randomized ops, biased toward the special cases
        for (int i = 0; i < 30; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) rb = 32'($urandom_range(1, 15));
            if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            run_op(rf, ra, rb);
        end

        // Flush at cycle 10 of a divide
        run_op(3'd5, 32'd1000, 32'd3);
        @(posedge clk); #1;
        exe_valid = 1'b1; exe_rtype = 1'b1; exe_funct7 = 7'b0000001;
        exe_funct3 = 3'd4; exe_rs1_data = 32'h1234_5678; exe_rs2_data = 32'd9;
        repeat (10) @(posedge clk);
        #1 exe_flush = 1'b1;
        @(negedge clk);
        check("flush_stall", {63'd0, muldiv_stall}, 64'd0);
        @(posedge clk); #1;
        exe_flush = 1'b0; exe_valid = 1'b0;
        @(negedge clk);
        check("flush_busy", {63'd0, muldiv_busy}, 64'd0);
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (muldiv_done) hit = 1'b1;
        end
        check("flush_no_done", {63'd0, hit}, 64'd0);
        check("flush_result", {32'd0, muldiv_result}, {32'd0, last_exp});
        $display("flush during DIV: result held at %h", muldiv_result);

        // Non-M ADD never stalls
        @(posedge clk); #1;
        exe_valid = 1'b1; exe_rtype = 1'b1; exe_funct7 = 7'd0; exe_funct3 = 3'd0;
        exe_rs1_data = 32'd3; exe_rs2_data = 32'd4;
        hit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (muldiv_stall || muldiv_busy) hit = 1'b1;
        end
        check("nonm_stall", {63'd0, hit}, 64'd0);
        $display("non-M ADD: no stall observed=%0d", hit);
        go_idle();

        // Asynchronous reset in the middle of a multiply
        run_op(3'd0, 32'd123, 32'd456);
        @(posedge clk); #1;
        exe_valid = 1'b1; exe_rtype = 1'b1; exe_funct7 = 7'b0000001;
        exe_funct3 = 3'd1; exe_rs1_data = 32'hDEAD_BEEF; exe_rs2_data = 32'h1357_9BDF;
        repeat (5) @(posedge clk);
        #2 exe_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_stall", {63'd0, muldiv_stall}, 64'd0);
        check("arst_busy", {63'd0, muldiv_busy}, 64'd0);
        check("arst_done", {63'd0, muldiv_done}, 64'd0);
        check("arst_result", {32'd0, muldiv_result}, 64'd0);
        $display("async reset mid-MUL: busy=%0d result=%h", muldiv_busy, muldiv_result);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op(3'd7, 32'd100, 32'd7);
        go_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
